mul_spi_arbiter: RTL and testbench

- Shares the serial multiplier slave between `NumRequesters` processor-side requesters.
- Acts as SPI master toward the multiplier and sequences each full transaction: start, operand shift-out, result wait, result shift-in.
- Arbitration is round-robin.
- Sits between the processor's execute stage(s) and the multiplier's SPI port.

---
 rtl/mul_spi_arbiter_pkg.sv | 21 ++
 rtl/Spi.sv | 11 +
 rtl/round_robin_arbiter.sv | 29 ++
 rtl/mul_spi_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mul_spi_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mul_spi_arbiter_pkg.sv
// Shared ISA-level definitions: register width, multiplier packet layout,
// and the SPI multiplier arbiter state encoding.
package Isa;
  localparam int REGISTER_SIZE = 8;

  typedef struct packed {
    logic [REGISTER_SIZE-1:0] op_2;
    logic [REGISTER_SIZE-1:0] op_1;
  } MulPacket;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_START,
    ARB_TX,
    ARB_WAIT,
    ARB_RX,
    ARB_DONE
  } mul_arb_state_t;

  localparam int MUL_ARB_TIMEOUT_CYCLES = 16;
endpackage

// File: rtl/Spi.sv
// Four-wire-less SPI bundle toward the multiplier slave (select, data out, data in).
interface Spi #(
  parameter int NssWidth = 1
);
  logic [NssWidth-1:0] nss;
  logic                mosi;
  logic                miso;

  modport MasterSpi (output nss, output mosi, input miso);
  modport SlaveSpi  (input nss, input mosi, output miso);
endinterface

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module round_robin_arbiter #(
  parameter int NumRequesters = 2
) (
  input  logic [NumRequesters-1:0]         req,
  input  logic [$clog2(NumRequesters)-1:0] ptr,
  output logic [NumRequesters-1:0]         grant,
  output logic [$clog2(NumRequesters)-1:0] grant_idx
);
  localparam int IdxW = $clog2(NumRequesters);

  logic            found;
  logic [IdxW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < NumRequesters; i++) begin
      idx = IdxW'((int'(ptr) + i) % NumRequesters);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mul_spi_arbiter.sv
// Round-robin SPI master sharing one serial multiplier between requesters.
// Optional slave-ready timeout and sticky fault: MUL_ARB_TIMEOUT_EN.
//   state | meaning
//   IDLE  | select high, arbitrate and accept one request
//   START | select low, start bit (mosi=1)
//   TX    | shift {op_2, op_1} out LSB first
//   WAIT  | wait for slave ready (miso=1)
//   RX    | shift product in LSB first
//   DONE  | select high, response pulse to the granted requester
module mul_spi_arbiter
  import Isa::*;
#(
  parameter int NumRequesters = 2,
  parameter int NssPosition   = 0,
  parameter int NssWidth      = 1,
  parameter int TimeoutCycles = MUL_ARB_TIMEOUT_CYCLES
) (
  input  logic                                       i_clock,
  input  logic                                       i_reset,
  input  logic [NumRequesters-1:0]                   i_req_valid,
  input  logic [NumRequesters-1:0][REGISTER_SIZE-1:0] i_req_op_1,
  input  logic [NumRequesters-1:0][REGISTER_SIZE-1:0] i_req_op_2,
  output logic [NumRequesters-1:0]                   o_req_ready,
  output logic [NumRequesters-1:0]                   o_rsp_valid,
  output logic [REGISTER_SIZE-1:0]                   o_rsp_result,
  output logic                                       o_rsp_error,
  output logic                                       o_busy,
  output logic                                       o_fault,
  Spi.MasterSpi                                      spi
);
  localparam int N      = REGISTER_SIZE;
  localparam int IdxW   = $clog2(NumRequesters);
  localparam int CntMax = (2 * N > TimeoutCycles) ? 2 * N : TimeoutCycles;
  localparam int CntW   = $clog2(CntMax + 1);
  localparam logic [NssWidth-1:0] NssSel = ~(NssWidth'(1) << NssPosition);

  mul_arb_state_t state_q, state_d;

  logic [NumRequesters-1:0] grant;
  logic [IdxW-1:0]          grant_idx, grant_q, ptr_q;
  MulPacket                 pkt_in;
  logic [2*N-1:0]           shift_q;
  logic [N-1:0]             result_q;
  logic [CntW-1:0]          cnt_q;
  logic [NssWidth-1:0]      nss_q;
  logic                     mosi_q, accept, blocked, timeout, cnt_done;

  round_robin_arbiter #(.NumRequesters(NumRequesters)) u_rr (
    .req      (i_req_valid),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  assign pkt_in   = '{op_2: i_req_op_2[grant_idx], op_1: i_req_op_1[grant_idx]};
  assign cnt_done = (cnt_q == '0);
  assign accept   = (state_q == ARB_IDLE) && !blocked && (|grant);

`ifdef MUL_ARB_TIMEOUT_EN
  logic err_q, fault_q;

  assign timeout = (state_q == ARB_WAIT) && !spi.miso && cnt_done;
  assign blocked = fault_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      err_q   <= 1'b0;
      fault_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q   <= 1'b1;
      fault_q <= 1'b1;
    end
  end

  assign o_rsp_error = err_q;
  assign o_fault     = fault_q;
`else
  assign timeout     = 1'b0;
  assign blocked     = 1'b0;
  assign o_rsp_error = 1'b0;
  assign o_fault     = 1'b0;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= ARB_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (accept) state_d = ARB_START;
      ARB_START: state_d = ARB_TX;
      ARB_TX:    if (cnt_done) state_d = ARB_WAIT;
      ARB_WAIT:  if (spi.miso) state_d = ARB_RX;
                 else if (timeout) state_d = ARB_DONE;
      ARB_RX:    if (cnt_done) state_d = ARB_DONE;
      ARB_DONE:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = '0;
    o_rsp_valid = '0;
    if (state_q == ARB_IDLE && !blocked && !i_reset) o_req_ready = grant;
    if (state_q == ARB_DONE) o_rsp_valid[grant_q] = 1'b1;
  end

  assign o_busy       = (state_q != ARB_IDLE);
  assign o_rsp_result = result_q;
  assign spi.nss      = nss_q;
  assign spi.mosi     = mosi_q;

  // cnt_q is reused: TX bit count, WAIT timeout, RX bit count.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      ptr_q    <= '0;
      grant_q  <= '0;
      shift_q  <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      nss_q    <= '1;
      mosi_q   <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: if (accept) begin
          shift_q  <= pkt_in;
          grant_q  <= grant_idx;
          ptr_q    <= (grant_idx == IdxW'(NumRequesters - 1)) ? '0 : grant_idx + 1'b1;
          result_q <= '0;
          cnt_q    <= CntW'(2 * N - 1);
          nss_q    <= NssSel;
          mosi_q   <= 1'b1;
        end
        ARB_START: begin
          mosi_q  <= shift_q[0];
          shift_q <= shift_q >> 1;
        end
        ARB_TX: if (cnt_done) begin
          mosi_q <= 1'b0;
          cnt_q  <= CntW'(TimeoutCycles);
        end else begin
          mosi_q  <= shift_q[0];
          shift_q <= shift_q >> 1;
          cnt_q   <= cnt_q - 1'b1;
        end
        ARB_WAIT: if (spi.miso) cnt_q <= CntW'(N - 1);
                  else if (timeout) nss_q <= '1;
                  else cnt_q <= cnt_q - 1'b1;
        ARB_RX: begin
          result_q <= {spi.miso, result_q[N-1:1]};
          if (cnt_done) nss_q <= '1;
          else          cnt_q <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_spi_arbiter.sv
// Directed bench for mul_spi_arbiter with a behavioural serial multiplier slave.
module tb_mul_spi_arbiter;
  import Isa::*;

  localparam int N = REGISTER_SIZE;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]        req_valid;
  logic [1:0][N-1:0] op1, op2;
  logic [1:0]        req_ready, rsp_valid;
  logic [N-1:0]      rsp_result;
  logic              rsp_error, busy, fault;

  Spi #(.NssWidth(2)) spi_if ();

  logic s_miso;
  assign spi_if.miso = s_miso;

  mul_spi_arbiter #(
    .NumRequesters(2), .NssPosition(1), .NssWidth(2), .TimeoutCycles(T)
  ) dut (
    .i_clock(clk), .i_reset(rst),
    .i_req_valid(req_valid), .i_req_op_1(op1), .i_req_op_2(op2),
    .o_req_ready(req_ready), .o_rsp_valid(rsp_valid),
    .o_rsp_result(rsp_result), .o_rsp_error(rsp_error),
    .o_busy(busy), .o_fault(fault), .spi(spi_if)
  );

  // Slave: start bit, 2N operand bits, one operate cycle, ready flag, N result bits.
  int          s_st, s_k;
  logic [15:0] s_sh;
  logic [7:0]  s_prod;
  bit          slave_mute = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_st <= 0; s_k <= 0; s_sh <= '0; s_prod <= '0; s_miso <= 1'b0;
    end else if (spi_if.nss[1]) begin
      s_st <= 0; s_miso <= 1'b0;
    end else begin
      case (s_st)
        0: if (spi_if.mosi) begin s_st <= 1; s_k <= 0; end
        1: begin
          s_sh <= {spi_if.mosi, s_sh[15:1]};
          if (s_k == 15) s_st <= 2;
          s_k <= s_k + 1;
        end
        2: begin
          s_prod <= 8'(s_sh[7:0] * s_sh[15:8]);
          if (slave_mute) s_st <= 5;
          else begin s_miso <= 1'b1; s_st <= 3; end
        end
        3: begin s_miso <= s_prod[0]; s_k <= 1; s_st <= 4; end
        4: if (s_k == 8) begin s_miso <= 1'b0; s_st <= 0; end
           else begin s_miso <= s_prod[s_k]; s_k <= s_k + 1; end
        default: ;
      endcase
    end
  end

  int checks = 0;
  int errors = 0;
  int last_wait;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One full transaction for requester r; returns in the first IDLE cycle after DONE.
  task automatic serve(input int r, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_p, input bit hold, input int late);
    int waited, pulses;
    logic [15:0] m;
    bit ready_leak, nss_bad;
    req_valid[r] = 1'b1; op1[r] = a; op2[r] = b;
    #1;
    waited = 0;
    while (req_ready[r] !== 1'b1 && waited < 100) begin tick(); waited++; end
    check("grant", req_ready, 32'd1 << r);
    last_wait = waited;
    m = '0; pulses = 0; ready_leak = 1'b0; nss_bad = 1'b0;
    for (int c = 1; c <= 3 * N + 4; c++) begin
      tick();
      if (c == 1 && !hold) req_valid[r] = 1'b0;
      if (c == 4 && late >= 0) req_valid[late] = 1'b1;
      #1;
      if (c == 1) begin
        check("start_nss", spi_if.nss, 2'b01);
        check("start_mosi", spi_if.mosi, 1'b1);
        check("start_busy", busy, 1'b1);
      end
      if (c >= 2 && c <= 2 * N + 1) begin
        m[c-2] = spi_if.mosi;
        if (spi_if.nss !== 2'b01) nss_bad = 1'b1;
      end
      if (req_ready !== 2'b00) ready_leak = 1'b1;
      if (c < 3 * N + 4 && rsp_valid !== 2'b00) pulses++;
    end
    check("mosi_seq", m, {b, a});
    check("tx_nss", nss_bad, 1'b0);
    check("early_rsp", pulses, 0);
    check("ready_while_busy", ready_leak, 1'b0);
    check("rsp_valid", rsp_valid, 32'd1 << r);
    check("rsp_result", rsp_result, exp_p);
    check("rsp_error", rsp_error, 1'b0);
    check("done_nss", spi_if.nss, 2'b11);
    tick();
    check("rsp_one_cycle", rsp_valid, 2'b00);
    check("idle_busy", busy, 1'b0);
  endtask

  initial begin
    int pulses, waited;
    req_valid = '0; op1 = '0; op2 = '0;
    tick();
    check("rst_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_result", rsp_result, 8'h00);
    check("rst_error", rsp_error, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_nss", spi_if.nss, 2'b11);
    check("rst_mosi", spi_if.mosi, 1'b0);
    tick();
    rst = 1'b0;

    // single multiply: 13*11 = 143
    serve(0, 8'd13, 8'd11, 8'h8F, 1'b0, -1);

    // contention right after reset, both held: 7*9=0x3F, 20*30=600 mod 256=0x58
    apply_reset();
    op1[0] = 8'd7;  op2[0] = 8'd9;
    op1[1] = 8'd20; op2[1] = 8'd30;
    req_valid = 2'b11;
    serve(0, 8'd7, 8'd9, 8'h3F, 1'b1, -1);
    serve(1, 8'd20, 8'd30, 8'h58, 1'b1, -1);
    serve(0, 8'd7, 8'd9, 8'h3F, 1'b1, -1);
    serve(1, 8'd20, 8'd30, 8'h58, 1'b0, -1);
    req_valid = '0;

    // overflow and zero
    serve(0, 8'd255, 8'd255, 8'h01, 1'b0, -1);
    serve(0, 8'd0, 8'd200, 8'h00, 1'b0, -1);
    serve(1, 8'd1, 8'd255, 8'hFF, 1'b0, -1);

    // busy gating: req1 raised during req0's TX, accepted in the first IDLE cycle
    op1[1] = 8'd6; op2[1] = 8'd7;
    serve(0, 8'd3, 8'd5, 8'h0F, 1'b0, 1);
    serve(1, 8'd6, 8'd7, 8'h2A, 1'b0, -1);
    check("gate_first_idle", last_wait, 0);

    // reset in cycle 6 of a transaction
    req_valid[0] = 1'b1; op1[0] = 8'd9; op2[0] = 8'd9;
    #1;
    waited = 0;
    while (req_ready[0] !== 1'b1 && waited < 100) begin tick(); waited++; end
    check("rst_tx_grant", req_ready, 2'b01);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) req_valid[0] = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("abort_nss", spi_if.nss, 2'b11);
    check("abort_mosi", spi_if.mosi, 1'b0);
    check("abort_rsp", rsp_valid, 2'b00);
    check("abort_busy", busy, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (rsp_valid !== 2'b00 || spi_if.nss !== 2'b11) pulses++;
    end
    check("abort_quiet", pulses, 0);
    serve(0, 8'd12, 8'd12, 8'h90, 1'b0, -1);

`ifdef MUL_ARB_TIMEOUT_EN
    // timeout: slave never raises miso; response in cycle 2N+3+T
    apply_reset();
    slave_mute = 1'b1;
    req_valid[0] = 1'b1; op1[0] = 8'd2; op2[0] = 8'd3;
    #1;
    waited = 0;
    while (req_ready[0] !== 1'b1 && waited < 100) begin tick(); waited++; end
    check("to_grant", req_ready, 2'b01);
    pulses = 0;
    for (int c = 1; c <= 2 * N + 3 + T; c++) begin
      tick();
      if (c < 2 * N + 3 + T && rsp_valid !== 2'b00) pulses++;
    end
    check("to_early_rsp", pulses, 0);
    check("to_rsp_valid", rsp_valid, 2'b01);
    check("to_error", rsp_error, 1'b1);
    check("to_result", rsp_result, 8'h00);
    tick();
    check("to_fault", fault, 1'b1);
    check("to_ready_blocked", req_ready, 2'b00);
    for (int c = 0; c < 5; c++) tick();
    check("to_ready_still_blocked", req_ready, 2'b00);
    check("to_still_idle", busy, 1'b0);
    req_valid = '0;
    slave_mute = 1'b0;
    apply_reset();
    check("to_fault_cleared", fault, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
